// File: rtl/sumador_pkg.sv
// Shared definitions for the selective-adder exercise.
// Holds default widths, the adder select codes and the state encoding of
// the checker FSM. Imported by the checker, its interface and the golden model.
package sumador_pkg;

    localparam int DEF_NB_DATA   = 3;
    localparam int DEF_NB_SUMA   = DEF_NB_DATA + 1;
    localparam int DEF_NB_ERRCNT = 8;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_DATA2 = 2'b00;
    localparam sel_t SEL_SUMA  = 2'b01;
    localparam sel_t SEL_DATA1 = 2'b10;
    localparam sel_t SEL_CERO  = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_S0   = 3'd1;
    localparam state_t ST_S1   = 3'd2;
    localparam state_t ST_S2   = 3'd3;
    localparam state_t ST_S3   = 3'd4;
    localparam state_t ST_FIN  = 3'd5;

    // Select code driven to the adder in each state; zero outside S0..S3.
    function automatic sel_t sel_of_state(input state_t st);
        case (st)
            ST_S0:   return SEL_DATA2;
            ST_S1:   return SEL_SUMA;
            ST_S2:   return SEL_DATA1;
            ST_S3:   return SEL_CERO;
            default: return SEL_DATA2;
        endcase
    endfunction

endpackage

// File: rtl/controlador_sumador_if.sv
// Bundle of the request handshake, the adder-facing bus and the check results.
// slave  : the checker (controlador_sumador)
// master : whoever issues requests and provides the adder result
//   i_valid/i_data1/i_data2 : request in      o_ready : checker idle
//   o_data1/o_data2/o_sel   : adder inputs     i_suma  : adder result
//   o_done/o_result/o_mismatch/o_err_count : check outcome
interface controlador_sumador_if
    import sumador_pkg::*;
#(
    parameter int NB_DATA   = DEF_NB_DATA,
    parameter int NB_SUMA   = NB_DATA + 1,
    parameter int NB_ERRCNT = DEF_NB_ERRCNT
);
    logic                 i_valid;
    logic                 o_ready;
    logic [NB_DATA-1:0]   i_data1;
    logic [NB_DATA-1:0]   i_data2;
    logic [NB_DATA-1:0]   o_data1;
    logic [NB_DATA-1:0]   o_data2;
    logic [1:0]           o_sel;
    logic [NB_SUMA-1:0]   i_suma;
    logic                 o_done;
    logic [NB_SUMA-1:0]   o_result;
    logic [3:0]           o_mismatch;
    logic [NB_ERRCNT-1:0] o_err_count;

    modport slave (
        input  i_valid, i_data1, i_data2, i_suma,
        output o_ready, o_data1, o_data2, o_sel, o_done,
               o_result, o_mismatch, o_err_count
    );

    modport master (
        output i_valid, i_data1, i_data2, i_suma,
        input  o_ready, o_data1, o_data2, o_sel, o_done,
               o_result, o_mismatch, o_err_count
    );

endinterface

// File: rtl/modelo_esperado.sv
// Combinational golden model of the selective adder.
//   data1, data2 : operands
//   sel          : 00 data2, 01 data1+data2, 10 data1, 11 zero
//   expected     : value a correct adder must produce
module modelo_esperado
    import sumador_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_SUMA = NB_DATA + 1
) (
    input  logic [NB_DATA-1:0] data1,
    input  logic [NB_DATA-1:0] data2,
    input  logic [1:0]         sel,
    output logic [NB_SUMA-1:0] expected
);

    always_comb begin
        expected = '0;
        case (sel)
            SEL_DATA2: expected = NB_SUMA'(data2);
            SEL_SUMA:  expected = NB_SUMA'(data1) + NB_SUMA'(data2);
            SEL_DATA1: expected = NB_SUMA'(data1);
            default:   expected = '0;
        endcase
    end

endmodule

// File: rtl/controlador_sumador.sv
// Built-in self-check wrapper for the selective adder.
// Accepts one operand pair, walks the adder through all four select codes,
// compares every result against the golden model and reports the outcome.
//   clk   : system clock, rising edge
//   i_rst : asynchronous reset, active high
//   bus   : request handshake, adder drive/sense and results (slave side)
//
// state | meaning
// IDLE  | ready, waiting for i_valid; operands latched on acceptance
// S0    | sel=00 driven, adder result checked against data2
// S1    | sel=01 driven, sum checked and captured into o_result
// S2    | sel=10 driven, adder result checked against data1
// S3    | sel=11 driven, adder result checked against zero
// FIN   | o_done pulse, mask and error count already published
module controlador_sumador
    import sumador_pkg::*;
#(
    parameter int NB_DATA   = DEF_NB_DATA,
    parameter int NB_SUMA   = NB_DATA + 1,
    parameter int NB_ERRCNT = DEF_NB_ERRCNT
) (
    input  logic                  clk,
    input  logic                  i_rst,
    controlador_sumador_if.slave  bus
);

    localparam logic [NB_ERRCNT-1:0] ERR_MAX = {NB_ERRCNT{1'b1}};

    state_t               state_q;
    state_t               state_d;
    logic [NB_DATA-1:0]   data1_q;
    logic [NB_DATA-1:0]   data2_q;
    logic [3:0]           mask_q;
    logic [3:0]           mask_next;
    logic [NB_SUMA-1:0]   result_q;
    logic [3:0]           mismatch_q;
    logic [NB_ERRCNT-1:0] err_q;
    logic [NB_SUMA-1:0]   expected;
    logic [1:0]           sel;
    logic                 ready;
    logic                 done;
    logic                 testing;

    modelo_esperado #(
        .NB_DATA (NB_DATA),
        .NB_SUMA (NB_SUMA)
    ) u_modelo (
        .data1    (data1_q),
        .data2    (data2_q),
        .sel      (sel),
        .expected (expected)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = bus.i_valid ? ST_S0 : ST_IDLE;
            ST_S0:   state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready   = 1'b0;
        done    = 1'b0;
        testing = 1'b0;
        sel     = sel_of_state(state_q);
        case (state_q)
            ST_IDLE:                    ready   = 1'b1;
            ST_S0, ST_S1, ST_S2, ST_S3: testing = 1'b1;
            ST_FIN:                     done    = 1'b1;
            default:                    ready   = 1'b0;
        endcase
    end

    // The sample of the current select lands in bit <sel> of the mask.
    always_comb begin
        mask_next = mask_q;
        if (testing && (bus.i_suma != expected)) begin
            mask_next = mask_q | (4'b0001 << sel);
        end
    end

    // Mask and error count are published on the S3->FIN edge so they are
    // already valid while o_done is high.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            data1_q    <= '0;
            data2_q    <= '0;
            mask_q     <= '0;
            result_q   <= '0;
            mismatch_q <= '0;
            err_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        data1_q <= bus.i_data1;
                        data2_q <= bus.i_data2;
                        mask_q  <= '0;
                    end
                end
                ST_S0, ST_S2: begin
                    mask_q <= mask_next;
                end
                ST_S1: begin
                    mask_q   <= mask_next;
                    result_q <= bus.i_suma;
                end
                ST_S3: begin
                    mask_q     <= mask_next;
                    mismatch_q <= mask_next;
                    if ((mask_next != 4'b0000) && (err_q != ERR_MAX)) begin
                        err_q <= err_q + NB_ERRCNT'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_done      = done;
    assign bus.o_sel       = sel;
    assign bus.o_data1     = data1_q;
    assign bus.o_data2     = data2_q;
    assign bus.o_result    = result_q;
    assign bus.o_mismatch  = mismatch_q;
    assign bus.o_err_count = err_q;

endmodule

// File: tb/tb_controlador_sumador.sv
// Self-checking bench for controlador_sumador with a configurable adder
// (correct, sel=11 returning 1, or stuck at zero) on the far side.
module tb_controlador_sumador;

    localparam int NB_DATA   = 3;
    localparam int NB_SUMA   = 4;
    localparam int NB_ERRCNT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   fault    = 0;

    controlador_sumador_if #(
        .NB_DATA   (NB_DATA),
        .NB_SUMA   (NB_SUMA),
        .NB_ERRCNT (NB_ERRCNT)
    ) bus ();

    controlador_sumador #(
        .NB_DATA   (NB_DATA),
        .NB_SUMA   (NB_SUMA),
        .NB_ERRCNT (NB_ERRCNT)
    ) dut (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Adder under test: 0 = correct, 1 = sel 11 returns 1, 2 = stuck at zero.
    always_comb begin
        bus.i_suma = '0;
        case (bus.o_sel)
            2'b00:   bus.i_suma = {1'b0, bus.o_data2};
            2'b01:   bus.i_suma = {1'b0, bus.o_data1} + {1'b0, bus.o_data2};
            2'b10:   bus.i_suma = {1'b0, bus.o_data1};
            default: bus.i_suma = (fault == 1) ? 4'd1 : 4'd0;
        endcase
        if (fault == 2) bus.i_suma = '0;
    end

    typedef struct {
        logic [2:0] d1;
        logic [2:0] d2;
        int         flt;
        logic [3:0] result;
        logic [3:0] mismatch;
        logic [7:0] err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge. Presents the request, waits (bounded) for ready,
    // then follows S0..S3 and returns 1 ns after the edge that starts FIN.
    task automatic do_txn(input logic [2:0] d1, input logic [2:0] d2,
                          input bit hold, output int waits);
        bus.i_valid = 1'b1;
        bus.i_data1 = d1;
        bus.i_data2 = d2;
        waits = 0;
        while (bus.o_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: ready never rose within 20 cycles");
        end
        check("ready_before_accept", 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) bus.i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sel_c%0d", k + 1), 32'(bus.o_sel), 32'(k));
            check($sformatf("data1_c%0d", k + 1), 32'(bus.o_data1), 32'(d1));
            check($sformatf("data2_c%0d", k + 1), 32'(bus.o_data2), 32'(d2));
            check($sformatf("ready_c%0d", k + 1), 32'(bus.o_ready), 32'd0);
            check($sformatf("done_c%0d", k + 1), 32'(bus.o_done), 32'd0);
            bus.i_data1 = d1 ^ 3'b111;
            bus.i_data2 = d2 ^ 3'b101;
            @(posedge clk);
            #1;
        end
        check("done_c5", 32'(bus.o_done), 32'd1);
        check("ready_c5", 32'(bus.o_ready), 32'd0);
        check("sel_c5", 32'(bus.o_sel), 32'd0);
    endtask

    initial begin
        int waits;

        vecs[0] = '{3'd5, 3'd6, 0, 4'd11, 4'b0000, 8'd0};
        vecs[1] = '{3'd7, 3'd7, 0, 4'd14, 4'b0000, 8'd0};
        vecs[2] = '{3'd0, 3'd0, 0, 4'd0,  4'b0000, 8'd0};
        vecs[3] = '{3'd2, 3'd3, 1, 4'd5,  4'b1000, 8'd1};
        vecs[4] = '{3'd1, 3'd1, 2, 4'd0,  4'b0111, 8'd2};
        vecs[5] = '{3'd7, 3'd0, 1, 4'd7,  4'b1000, 8'd3};
        vecs[6] = '{3'd4, 3'd3, 0, 4'd7,  4'b0000, 8'd3};
        vecs[7] = '{3'd3, 3'd0, 2, 4'd0,  4'b0110, 8'd4};

        bus.i_valid = 1'b0;
        bus.i_data1 = '0;
        bus.i_data2 = '0;

        #3;
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_sel", 32'(bus.o_sel), 32'd0);
        check("rst_data1", 32'(bus.o_data1), 32'd0);
        check("rst_data2", 32'(bus.o_data2), 32'd0);
        check("rst_result", 32'(bus.o_result), 32'd0);
        check("rst_mismatch", 32'(bus.o_mismatch), 32'd0);
        check("rst_err", 32'(bus.o_err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_stays", 32'(bus.o_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            fault = vecs[i].flt;
            @(negedge clk);
            do_txn(vecs[i].d1, vecs[i].d2, 1'b0, waits);
            check($sformatf("v%0d_result", i), 32'(bus.o_result), 32'(vecs[i].result));
            check($sformatf("v%0d_mismatch", i), 32'(bus.o_mismatch), 32'(vecs[i].mismatch));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_err", i), 32'(bus.o_err_count), 32'(vecs[i].err));
            check($sformatf("v%0d_done_low", i), 32'(bus.o_done), 32'd0);
            check($sformatf("v%0d_ready_back", i), 32'(bus.o_ready), 32'd1);
        end

        // Continuous i_valid: one acceptance every 6 cycles, operands held.
        fault = 0;
        @(negedge clk);
        do_txn(3'd1, 3'd2, 1'b1, waits);
        check("cont0_wait", 32'(waits), 32'd0);
        check("cont0_result", 32'(bus.o_result), 32'd3);
        @(negedge clk);
        do_txn(3'd6, 3'd5, 1'b1, waits);
        check("cont1_wait", 32'(waits), 32'd1);
        check("cont1_result", 32'(bus.o_result), 32'd11);
        @(negedge clk);
        do_txn(3'd7, 3'd1, 1'b0, waits);
        check("cont2_wait", 32'(waits), 32'd1);
        check("cont2_result", 32'(bus.o_result), 32'd8);
        check("cont2_mismatch", 32'(bus.o_mismatch), 32'd0);
        check("cont_err_held", 32'(bus.o_err_count), 32'd4);

        // Reset while in S2.
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data1 = 3'd3;
        bus.i_data2 = 3'd4;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_sel_s2", 32'(bus.o_sel), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        check("mid_rst_sel", 32'(bus.o_sel), 32'd0);
        check("mid_rst_err", 32'(bus.o_err_count), 32'd0);
        check("mid_rst_data1", 32'(bus.o_data1), 32'd0);
        check("mid_rst_result", 32'(bus.o_result), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("mid_rst_no_done%0d", c), 32'(bus.o_done), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        do_txn(3'd3, 3'd4, 1'b0, waits);
        check("post_rst_wait", 32'(waits), 32'd0);
        check("post_rst_result", 32'(bus.o_result), 32'd7);
        check("post_rst_mismatch", 32'(bus.o_mismatch), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_err", 32'(bus.o_err_count), 32'd0);

        // Saturation with a stuck-at-zero adder.
        fault = 2;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            do_txn(3'd1, 3'd1, 1'b0, waits);
            if (i == 0) check("sat_mismatch", 32'(bus.o_mismatch), 32'b0111);
            @(posedge clk);
            #1;
            if (i == 253) check("sat_err_254", 32'(bus.o_err_count), 32'd254);
            if (i == 254) check("sat_err_255", 32'(bus.o_err_count), 32'd255);
            if (i == 299) check("sat_err_hold", 32'(bus.o_err_count), 32'd255);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_sumador.md
Name: controlador_sumador

Overview:
Initiator/checker on the far side of the selective-adder interface. It accepts one operand pair through a valid/ready handshake and drives the adder's data1/data2/sel inputs through all four select codes, one per cycle. It samples the adder's sum output each cycle and compares it against an internally computed expected value. It reports the registered sum, a per-select mismatch mask, and a saturating error count. It is the built-in self-check wrapper around the adder in the GP01 exercise top level.

Parameters:
NB_DATA, 3, operand width (adder inputs)
NB_SUMA, NB_DATA+1, sum width (adder output)
NB_ERRCNT, 8, width of saturating error counter

Ports:
clk  input  1  system clock, rising edge
i_rst  input  1  asynchronous reset, active-high
i_valid  input  1  request strobe; operands valid
o_ready  output  1  high when idle and able to accept a request
i_data1  input  NB_DATA  operand 1 of request
i_data2  input  NB_DATA  operand 2 of request
o_data1  output  NB_DATA  operand 1 driven to adder (held for whole transaction)
o_data2  output  NB_DATA  operand 2 driven to adder
o_sel  output  2  select code driven to adder
i_suma  input  NB_SUMA  adder result (combinational from o_data1/o_data2/o_sel)
o_done  output  1  one-cycle pulse at end of transaction
o_result  output  NB_SUMA  sum captured with sel=01, valid from o_done onward
o_mismatch  output  4  bit k set if sel=k sample differed from expected; valid with o_done
o_err_count  output  NB_ERRCNT  number of transactions with any mismatch, saturating

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - State returns to IDLE.
  - o_ready=1, o_done=0, o_sel=2'b00, o_data1=0, o_data2=0, o_result=0, o_mismatch=0, o_err_count=0.
- States: IDLE, S0, S1, S2, S3, FIN. o_sel is registered and equals the state index in S0..S3; it is 2'b00 in IDLE and FIN.
- IDLE:
  - o_ready=1.
  - When i_valid=1, i_data1/i_data2 are latched into o_data1/o_data2, the internal mismatch is cleared, and the next state is S0.
  - When i_valid=0, the block stays in IDLE.
- S0..S3:
  - o_ready=0; i_valid is ignored and nothing is queued.
  - At each clock edge, i_suma is compared with the expected value:
    - sel 00 -> {0,data2}
    - sel 01 -> data1+data2, full NB_SUMA width, no overflow possible
    - sel 10 -> {0,data1}
    - sel 11 -> all zeros
  - A difference sets bit k of the internal mask.
  - In S1, i_suma is also captured into o_result.
  - Sk advances to S(k+1); S3 advances to FIN.
- FIN (one cycle):
  - o_done=1 and o_mismatch takes the final mask.
  - If the mask is nonzero, o_err_count increments, saturating at 2^NB_ERRCNT-1.
  - Next state is IDLE; o_ready goes high in the following cycle.
- Latency: handshake accepted at edge 0; S0..S3 occupy cycles 1-4; o_done is high in cycle 5. The next request can be accepted at the earliest in cycle 6. Throughput is one transaction per 6 cycles.
- o_result and o_mismatch hold their values until the next FIN. o_err_count holds until reset.
- i_valid asserted in the same cycle as reset deassertion: the request is accepted on the first clock edge after reset deasserts.
- X or invalid states decode to IDLE.

Decomposition:
- Shared package sumador_pkg holds:
  - NB_DATA and NB_SUMA defaults.
  - Select codes SEL_DATA2=2'b00, SEL_SUMA=2'b01, SEL_DATA1=2'b10, SEL_CERO=2'b11.
  - State encoding localparams.
- Sub-module modelo_esperado: combinational golden model (data1, data2, sel -> expected NB_SUMA). It is instantiated once in this block and reused by testbenches.

Test Plan:
- Correct adder attached; request d1=3'd5, d2=3'd6 -> o_sel sequence 00,01,10,11 in cycles 1-4; o_done in cycle 5; o_result=4'd11; o_mismatch=4'b0000; o_err_count=0.
- Boundary operands d1=3'd7, d2=3'd7 -> o_result=4'd14, no mismatch. d1=0, d2=0 -> o_result=0, no mismatch.
- Faulty adder model (sel=11 returns 4'd1); request d1=2, d2=3 -> o_mismatch=4'b1000; o_err_count=1; o_result=4'd5.
- i_valid held high continuously with changing operands -> new transactions accepted only in IDLE, every 6 cycles. Operands latched at acceptance are held on o_data1/o_data2 through S3 even though i_data changes.
- Assert i_rst during S2 -> outputs immediately take reset values (o_ready=1, o_sel=0, o_err_count=0); no o_done. A new request after reset completes normally.
- Stuck-at-zero adder; 300 requests with d1=1, d2=1 -> o_err_count saturates at 255 and does not wrap.
